// File: rtl/conv2d_stream_engine.sv
// Streaming KxK "valid" convolution engine with bias, selectable stride and optional ReLU.
// A K-row line buffer feeds one sequential MAC, which consumes one kernel tap per cycle.
module conv2d_stream_engine #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int K      = 3,
   parameter int STRIDE = 1,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   localparam int KK    = K * K,
   localparam int KA_W  = (KK > 1) ? $clog2(KK) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              relu_en,
   input  logic [ACC_W-1:0]  bias,
   input  logic              k_wr_en,
   input  logic [KA_W-1:0]   k_wr_addr,
   input  logic [DATA_W-1:0] k_wr_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int OUT_W    = (IMG_W - K) / STRIDE + 1;
   localparam int OUT_H    = (IMG_H - K) / STRIDE + 1;
   localparam int LB       = K * IMG_W;
   localparam int LB_AW    = (LB > 1) ? $clog2(LB) : 1;
   localparam int MAX_COL  = IMG_W - K;
   localparam int LAST_COL = (OUT_W - 1) * STRIDE;
   localparam int ROW_STEP = IMG_W - K + 1;
   localparam int REFILL_N = STRIDE * IMG_W;
   localparam int PC_N     = (LB > REFILL_N) ? LB : REFILL_N;
   localparam int PC_W     = $clog2(PC_N + 1);
   localparam int RW       = $clog2(OUT_H + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_COMPUTE, S_EMIT, S_ADVANCE, S_REFILL, S_DONE
   } state_t;

   state_t                    state_r;
   logic signed [DATA_W-1:0]  w_r  [KK];
   logic signed [DATA_W-1:0]  lb_r [LB];
   logic signed [ACC_W-1:0]   bias_r;
   logic signed [ACC_W-1:0]   acc_r;
   logic                      relu_r;
   logic [PC_W-1:0]           pix_cnt_r;
   logic [LB_AW-1:0]          col_r;
   logic [LB_AW-1:0]          tap_off_r;
   logic [LB_AW-1:0]          tc_r;
   logic [KA_W-1:0]           tap_r;
   logic [RW-1:0]             out_row_r;
   logic                      pix_ready_r;
   logic                      out_valid_r;
   logic [ACC_W-1:0]          out_data_r;
   logic                      out_last_r;
   logic                      busy_r;
   logic                      done_r;

   logic                      pix_fire_s;
   logic [LB_AW-1:0]          lb_idx_s;
   logic signed [DATA_W-1:0]  tap_pix_s;
   logic signed [DATA_W-1:0]  tap_w_s;
   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [ACC_W-1:0]   prod_ext_s;
   logic signed [ACC_W-1:0]   acc_next_s;
   logic [ACC_W-1:0]          relu_out_s;
   logic [LB_AW:0]            col_next_s;
   logic                      last_out_s;

   assign pix_ready = pix_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign done      = done_r;

   assign pix_fire_s = pix_valid && pix_ready_r;

   // The buffer holds the K most recent rows oldest-first, so tap (r,c) at column x sits at r*IMG_W + x + c.
   assign lb_idx_s   = tap_off_r + col_r;
   assign tap_pix_s  = lb_r[lb_idx_s];
   assign tap_w_s    = w_r[tap_r];
   assign prod_s     = tap_pix_s * tap_w_s;
   assign prod_ext_s = ACC_W'(prod_s);
   assign acc_next_s = acc_r + prod_ext_s;
   assign relu_out_s = (relu_r && acc_next_s[ACC_W-1]) ? {ACC_W{1'b0}} : acc_next_s;
   assign col_next_s = {1'b0, col_r} + (LB_AW + 1)'(STRIDE);
   assign last_out_s = (out_row_r == RW'(OUT_H - 1)) && (col_r == LB_AW'(LAST_COL));

   // Line buffer: every accepted pixel shifts in at the tail, discarding the oldest.
   always_ff @(posedge clk) begin
      if (pix_fire_s) begin
         for (int i = 0; i < LB - 1; i++) begin
            lb_r[i] <= lb_r[i + 1];
         end
         lb_r[LB-1] <= pix_data;
      end
   end

   // Frame sequencer, MAC datapath and registered stream outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         for (int i = 0; i < KK; i++) begin
            w_r[i] <= {DATA_W{1'b0}};
         end
         bias_r      <= {ACC_W{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         relu_r      <= 1'b0;
         pix_cnt_r   <= {PC_W{1'b0}};
         col_r       <= {LB_AW{1'b0}};
         tap_off_r   <= {LB_AW{1'b0}};
         tc_r        <= {LB_AW{1'b0}};
         tap_r       <= {KA_W{1'b0}};
         out_row_r   <= {RW{1'b0}};
         pix_ready_r <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {ACC_W{1'b0}};
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (k_wr_en && (k_wr_addr < KA_W'(KK))) begin
                  w_r[k_wr_addr] <= k_wr_data;
               end
               if (start) begin
                  bias_r      <= bias;
                  acc_r       <= bias;
                  relu_r      <= relu_en;
                  pix_cnt_r   <= {PC_W{1'b0}};
                  col_r       <= {LB_AW{1'b0}};
                  tap_off_r   <= {LB_AW{1'b0}};
                  tc_r        <= {LB_AW{1'b0}};
                  tap_r       <= {KA_W{1'b0}};
                  out_row_r   <= {RW{1'b0}};
                  pix_ready_r <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= S_FILL;
               end
            end
            S_FILL: begin
               if (pix_fire_s) begin
                  if (pix_cnt_r == PC_W'(LB - 1)) begin
                     pix_ready_r <= 1'b0;
                     state_r     <= S_COMPUTE;
                  end else begin
                     pix_cnt_r <= pix_cnt_r + PC_W'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (tap_r == KA_W'(KK - 1)) begin
                  out_data_r  <= relu_out_s;
                  out_last_r  <= last_out_s;
                  out_valid_r <= 1'b1;
                  acc_r       <= bias_r;
                  tap_r       <= {KA_W{1'b0}};
                  tc_r        <= {LB_AW{1'b0}};
                  tap_off_r   <= {LB_AW{1'b0}};
                  state_r     <= S_EMIT;
               end else begin
                  acc_r <= acc_next_s;
                  tap_r <= tap_r + KA_W'(1);
                  if (tc_r == LB_AW'(K - 1)) begin
                     tc_r      <= {LB_AW{1'b0}};
                     tap_off_r <= tap_off_r + LB_AW'(ROW_STEP);
                  end else begin
                     tc_r      <= tc_r + LB_AW'(1);
                     tap_off_r <= tap_off_r + LB_AW'(1);
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
                  state_r     <= S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               if (col_next_s <= (LB_AW + 1)'(MAX_COL)) begin
                  col_r   <= col_next_s[LB_AW-1:0];
                  state_r <= S_COMPUTE;
               end else if (out_row_r == RW'(OUT_H - 1)) begin
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  col_r       <= {LB_AW{1'b0}};
                  out_row_r   <= out_row_r + RW'(1);
                  pix_cnt_r   <= {PC_W{1'b0}};
                  pix_ready_r <= 1'b1;
                  state_r     <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (pix_fire_s) begin
                  if (pix_cnt_r == PC_W'(REFILL_N - 1)) begin
                     pix_ready_r <= 1'b0;
                     state_r     <= S_COMPUTE;
                  end else begin
                     pix_cnt_r <= pix_cnt_r + PC_W'(1);
                  end
               end
            end
            S_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               pix_ready_r <= 1'b0;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench: a stride-1 and a stride-2 engine share stimulus; results are checked
// against a direct nested-loop convolution of the stored image and kernel.
module tb_conv2d_stream_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start_a, start_b, relu_en, k_wr_en, pix_valid, out_ready, sel;
   logic [31:0] bias;
   logic [3:0]  k_wr_addr;
   logic [15:0] k_wr_data, pix_data;
   logic        pix_ready_a, out_valid_a, out_last_a, busy_a, done_a;
   logic        pix_ready_b, out_valid_b, out_last_b, busy_b, done_b;
   logic [31:0] out_data_a, out_data_b;
   logic        o_pix_ready, o_valid, o_last, o_busy, o_done;
   logic [31:0] o_data;

   int          total_cnt = 0;
   int          bad_cnt   = 0;
   int          img [64];
   int          kern [9];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   int          exp_pix;

   conv2d_stream_engine dut_a (
      .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_en), .bias(bias),
      .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready_a), .pix_data(pix_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .out_last(out_last_a), .busy(busy_a), .done(done_a)
   );

   conv2d_stream_engine #(.STRIDE(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .relu_en(relu_en), .bias(bias),
      .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready_b), .pix_data(pix_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .out_last(out_last_b), .busy(busy_b), .done(done_b)
   );

   assign o_pix_ready = sel ? pix_ready_b : pix_ready_a;
   assign o_valid     = sel ? out_valid_b : out_valid_a;
   assign o_last      = sel ? out_last_b  : out_last_a;
   assign o_busy      = sel ? busy_b      : busy_a;
   assign o_done      = sel ? done_b      : done_a;
   assign o_data      = sel ? out_data_b  : out_data_a;

   // Direct "valid" convolution of an 8x8 image with the 3x3 kernel, wrapped to 32 bits.
   function automatic void build_expected(input int stride, input int bias_v, input bit relu_v);
      int ow, oh;
      longint s;
      logic [31:0] v;
      ow = (8 - 3) / stride + 1;
      oh = (8 - 3) / stride + 1;
      exp_q.delete();
      for (int oy = 0; oy < oh; oy++) begin
         for (int ox = 0; ox < ow; ox++) begin
            s = longint'(bias_v);
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  s += longint'(img[(oy * stride + r) * 8 + ox * stride + c]) * longint'(kern[r * 3 + c]);
               end
            end
            v = s[31:0];
            if (relu_v && $signed(v) < 0) v = 32'd0;
            exp_q.push_back(v);
         end
      end
      exp_pix = 3 * 8 + (oh - 1) * stride * 8;
   endfunction

   task automatic write_kernel();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         k_wr_en   = 1'b1;
         k_wr_addr = 4'(i);
         k_wr_data = 16'(kern[i]);
      end
      @(negedge clk);
      k_wr_en = 1'b0;
   endtask

   task automatic run_frame(input bit use_b, input bit stall, input int bias_v, input bit relu_v,
                            input bit poke, input int late_kw, input int abort_after);
      int cyc, n, n_done, pix_i, fill_cyc, prev_cyc;
      bit hold_pend, hold_last, seen_valid, aborted;
      logic [31:0] hold_data;
      n = 0; n_done = 0; pix_i = 0; fill_cyc = -100; prev_cyc = 0;
      hold_pend = 1'b0; hold_last = 1'b0; seen_valid = 1'b0; aborted = 1'b0; hold_data = 32'd0;
      got_q.delete();
      sel = use_b;
      @(negedge clk);
      bias    = bias_v;
      relu_en = relu_v;
      start_a = !use_b;
      start_b = use_b;
      if (late_kw >= 0) begin
         k_wr_en   = 1'b1;
         k_wr_addr = 4'(late_kw);
         k_wr_data = 16'(kern[late_kw]);
      end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; k_wr_en = 1'b0;
      total_cnt++;
      if (o_busy !== 1'b1 || o_pix_ready !== 1'b1) begin
         bad_cnt++;
         $display("FAIL start_busy: busy=%b pix_ready=%b, required 1 1", o_busy, o_pix_ready);
      end
      cyc = 0;
      while (cyc < 4000) begin
         if (hold_pend) begin
            total_cnt++;
            if (o_valid !== 1'b1 || o_data !== hold_data || o_last !== hold_last) begin
               bad_cnt++;
               $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b", o_valid, o_data, o_last, hold_data, hold_last);
            end
         end
         if (o_valid && !seen_valid) begin
            seen_valid = 1'b1;
            total_cnt++;
            if (cyc - fill_cyc !== 10) begin
               bad_cnt++;
               $display("FAIL first_latency: %0d cycles, required 10", cyc - fill_cyc);
            end
         end
         if (o_done) begin
            n_done++;
            total_cnt++;
            if (o_busy !== 1'b1 || n !== exp_q.size()) begin
               bad_cnt++;
               $display("FAIL done_pulse: busy=%b outputs=%0d, required 1 %0d", o_busy, n, exp_q.size());
            end
         end else if (n_done > 0) begin
            total_cnt++;
            if (o_busy !== 1'b0) begin
               bad_cnt++;
               $display("FAIL busy_fall: busy=%b, required 0", o_busy);
            end
            break;
         end
         pix_valid = (pix_i < 64) && (!stall || ($urandom_range(0, 1) == 1));
         pix_data  = (pix_i < 64) ? 16'(img[pix_i]) : 16'h0000;
         if (pix_valid && o_pix_ready) begin
            pix_i++;
            if (pix_i == 24) fill_cyc = cyc;
         end
         out_ready = !stall || ($urandom_range(0, 1) == 1);
         if (o_valid && out_ready) begin
            total_cnt++;
            if (n >= exp_q.size()) begin
               bad_cnt++;
               $display("FAIL extra_output: index %0d data=%h, required none", n, o_data);
            end else if (o_data !== exp_q[n] || o_last !== (n == exp_q.size() - 1)) begin
               bad_cnt++;
               $display("FAIL out_%0d: data=%h last=%b, required %h %b", n, o_data, o_last, exp_q[n], (n == exp_q.size() - 1));
            end
            got_q.push_back(o_data);
            if (!stall && n == 1) begin
               total_cnt++;
               if (cyc - prev_cyc !== 11) begin
                  bad_cnt++;
                  $display("FAIL out_spacing: %0d cycles, required 11", cyc - prev_cyc);
               end
            end
            prev_cyc  = cyc;
            n++;
            hold_pend = 1'b0;
         end else begin
            hold_pend = o_valid;
            hold_data = o_data;
            hold_last = o_last;
         end
         if (poke) begin
            k_wr_en   = 1'b1;
            k_wr_addr = 4'($urandom_range(0, 15));
            k_wr_data = 16'($urandom);
            if (use_b) start_b = 1'b1;
            else start_a = 1'b1;
         end
         cyc++;
         if (abort_after > 0 && n == abort_after) begin
            aborted = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (aborted) begin
         @(negedge clk);
         rst = 1'b0;
      end
      pix_valid = 1'b0; out_ready = 1'b0; k_wr_en = 1'b0; start_a = 1'b0; start_b = 1'b0;
      if (!aborted) begin
         total_cnt++;
         if (cyc >= 4000 || n !== exp_q.size() || n_done !== 1 || pix_i !== exp_pix) begin
            bad_cnt++;
            $display("FAIL frame_end: cycles=%0d outputs=%0d dones=%0d pixels=%0d, required <4000 %0d 1 %0d",
                     cyc, n, n_done, pix_i, exp_q.size(), exp_pix);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({out_valid_a, out_last_a, pix_ready_a, busy_a, done_a} !== 5'b0 || out_data_a !== 32'd0) begin
         bad_cnt++;
         $display("FAIL reset_a: flags=%b data=%h, required 00000 0", {out_valid_a, out_last_a, pix_ready_a, busy_a, done_a}, out_data_a);
      end
      total_cnt++;
      if ({out_valid_b, out_last_b, pix_ready_b, busy_b, done_b} !== 5'b0 || out_data_b !== 32'd0) begin
         bad_cnt++;
         $display("FAIL reset_b: flags=%b data=%h, required 00000 0", {out_valid_b, out_last_b, pix_ready_b, busy_b, done_b}, out_data_b);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 64; i++) img[i] = i / 8;
      kern = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
      write_kernel();
      build_expected(1, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 0);
      total_cnt++;
      if (got_q.size() != 36 || got_q[0] !== 32'd6 || got_q[35] !== 32'd6) begin
         bad_cnt++;
         $display("FAIL basic_value: count=%0d first=%h, required 36 00000006", got_q.size(), got_q[0]);
      end
   endtask

   task automatic test_relu();
      for (int i = 0; i < 64; i++) img[i] = 7 - i / 8;
      build_expected(1, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 0);
      total_cnt++;
      if (got_q.size() == 0 || got_q[0] !== 32'hFFFF_FFFA) begin
         bad_cnt++;
         $display("FAIL neg_value: got %h, required fffffffa", got_q[0]);
      end
      build_expected(1, 0, 1'b1);
      run_frame(1'b0, 1'b0, 0, 1'b1, 1'b0, -1, 0);
      total_cnt++;
      if (got_q.size() == 0 || got_q[0] !== 32'd0) begin
         bad_cnt++;
         $display("FAIL relu_value: got %h, required 00000000", got_q[0]);
      end
      build_expected(1, 10, 1'b0);
      run_frame(1'b0, 1'b0, 10, 1'b0, 1'b0, -1, 0);
      total_cnt++;
      if (got_q.size() == 0 || got_q[0] !== 32'd4) begin
         bad_cnt++;
         $display("FAIL bias_value: got %h, required 00000004", got_q[0]);
      end
   endtask

   task automatic test_same_cycle_kwr();
      for (int i = 0; i < 64; i++) img[i] = $urandom_range(0, 200) - 100;
      kern = '{1, 2, 3, 4, 0, 6, 7, 8, 9};
      write_kernel();
      kern[4] = 5;
      build_expected(1, -3, 1'b0);
      run_frame(1'b0, 1'b0, -3, 1'b0, 1'b0, 4, 0);
   endtask

   task automatic test_random_stall();
      logic signed [15:0] t;
      int b;
      bit r;
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < 64; i++) begin
            t = 16'($urandom);
            img[i] = t;
         end
         for (int i = 0; i < 9; i++) begin
            t = 16'($urandom);
            kern[i] = t;
         end
         b = $urandom;
         r = 1'($urandom_range(0, 1));
         write_kernel();
         build_expected(1, b, r);
         run_frame(1'b0, 1'b1, b, r, 1'b1, -1, 0);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 64; i++) img[i] = 32767;
      for (int i = 0; i < 9; i++) kern[i] = 32767;
      write_kernel();
      build_expected(1, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 0);
      total_cnt++;
      if (got_q.size() == 0 || got_q[0] !== 32'h3FF7_0009) begin
         bad_cnt++;
         $display("FAIL wrap_value: got %h, required 3ff70009", got_q[0]);
      end
   endtask

   task automatic test_stride2();
      for (int i = 0; i < 64; i++) img[i] = i;
      kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      write_kernel();
      build_expected(2, 0, 1'b0);
      run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0, -1, 0);
      total_cnt++;
      if (got_q.size() != 9 || got_q[0] !== 32'd9 || got_q[4] !== 32'd27 || got_q[8] !== 32'd45) begin
         bad_cnt++;
         $display("FAIL stride2_value: count=%0d first=%h, required 9 00000009", got_q.size(), got_q[0]);
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_abort();
      bit seen;
      for (int i = 0; i < 64; i++) img[i] = i / 8;
      kern = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
      write_kernel();
      build_expected(1, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, -1, 10);
      @(negedge clk);
      total_cnt++;
      if ({busy_a, out_valid_a, done_a, pix_ready_a} !== 4'b0) begin
         bad_cnt++;
         $display("FAIL abort_state: busy/valid/done/ready=%b, required 0000", {busy_a, out_valid_a, done_a, pix_ready_a});
      end
      rst = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done_a || out_valid_a || busy_a) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) begin
         bad_cnt++;
         $display("FAIL abort_quiet: activity=%b, required 0", seen);
      end
      for (int i = 0; i < 9; i++) kern[i] = 0;
      build_expected(1, 5, 1'b0);
      run_frame(1'b0, 1'b0, 5, 1'b0, 1'b0, -1, 0);
      kern = '{2, 0, -1, 3, 1, 0, 0, -2, 1};
      for (int i = 0; i < 64; i++) img[i] = $urandom_range(0, 1000) - 500;
      write_kernel();
      build_expected(1, 7, 1'b0);
      run_frame(1'b0, 1'b0, 7, 1'b0, 1'b0, -1, 0);
   endtask

   initial begin
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0; relu_en = 1'b0; bias = 32'd0; sel = 1'b0;
      k_wr_en = 1'b0; k_wr_addr = 4'd0; k_wr_data = 16'd0;
      pix_valid = 1'b0; pix_data = 16'd0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_relu();
      test_same_cycle_kwr();
      test_random_stall();
      test_overflow();
      test_stride2();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
